// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: width constant, access-size
// encodings carried on funct3, the control FSM states and an alignment helper.
package load_store_unit_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } lsu_state_e;

    // Unsupported encodings fall into the word case, so they need full alignment.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_B, F3_BU: return 1'b0;
            F3_H, F3_HU: return off[0];
            default:     return (off != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Byte-lane steering between the core and a 32-bit word bus: store-side
// byte enables and replicated write data, load-side lane pick and extension.
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      offset_i,
    input  logic [XLEN-1:0] store_data_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [3:0]      be_o,
    output logic [XLEN-1:0] wdata_o,
    output logic [XLEN-1:0] load_data_o
);

    logic [XLEN-1:0] shifted;

    // Word behaviour is the default; byte and half sizes override enables, data and extension.
    always_comb begin
        shifted     = rdata_i >> {offset_i, 3'b000};
        be_o        = 4'b1111;
        wdata_o     = store_data_i;
        load_data_o = rdata_i;
        case (funct3_i)
            F3_B: begin
                be_o        = 4'b0001 << offset_i;
                wdata_o     = {4{store_data_i[7:0]}};
                load_data_o = {{24{shifted[7]}}, shifted[7:0]};
            end
            F3_BU: begin
                be_o        = 4'b0001 << offset_i;
                wdata_o     = {4{store_data_i[7:0]}};
                load_data_o = {24'b0, shifted[7:0]};
            end
            F3_H: begin
                be_o        = 4'b0011 << offset_i;
                wdata_o     = {2{store_data_i[15:0]}};
                load_data_o = {{16{shifted[15]}}, shifted[15:0]};
            end
            F3_HU: begin
                be_o        = 4'b0011 << offset_i;
                wdata_o     = {2{store_data_i[15:0]}};
                load_data_o = {16'b0, shifted[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: accepts one op at a time from execute, runs at most one
// req/gnt/rvalid bus access, and emits a single registered writeback beat.
module load_store_unit #(
    parameter int XLEN       = load_store_unit_pkg::XLEN,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic [XLEN-1:0]       ex_alu_result,
    input  logic [XLEN-1:0]       ex_store_data,
    input  logic [2:0]            ex_funct3,
    input  logic                  ex_mem_read,
    input  logic                  ex_mem_write,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_reg_write,
    input  logic                  flush,
    output logic                  mem_req,
    output logic [XLEN-1:0]       mem_addr,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [XLEN-1:0]       mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [XLEN-1:0]       mem_rdata,
    output logic                  wb_valid,
    output logic [XLEN-1:0]       wb_data,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  wb_reg_write,
    output logic                  wb_misaligned
);

    import load_store_unit_pkg::*;

    lsu_state_e            state_q, state_d;
    logic [XLEN-1:0]       addr_q, addr_d;
    logic [XLEN-1:0]       sdata_q, sdata_d;
    logic [2:0]            funct3_q, funct3_d;
    logic                  we_q, we_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic                  regw_q, regw_d;
    logic                  kill_q, kill_d;
    logic                  wb_valid_q, wb_valid_d;
    logic [XLEN-1:0]       wb_data_q, wb_data_d;
    logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
    logic                  wb_regw_q, wb_regw_d;
    logic                  wb_mis_q, wb_mis_d;

    logic                  accept;
    logic                  is_mem;
    logic                  misaligned;
    logic [3:0]            lane_be;
    logic [XLEN-1:0]       lane_wdata;
    logic [XLEN-1:0]       lane_load;

    assign ex_ready   = (state_q == IDLE);
    assign accept     = ex_valid && ex_ready && !flush;
    assign is_mem     = ex_mem_read || ex_mem_write;
    assign misaligned = is_misaligned(ex_funct3, ex_alu_result[1:0]);

    // Bus outputs come from latched op fields and are forced to zero outside REQ.
    assign mem_req   = (state_q == REQ);
    assign mem_addr  = mem_req ? {addr_q[XLEN-1:2], 2'b00} : '0;
    assign mem_we    = mem_req && we_q;
    assign mem_be    = mem_req ? lane_be : 4'b0000;
    assign mem_wdata = mem_req ? lane_wdata : '0;

    assign wb_valid      = wb_valid_q;
    assign wb_data       = wb_data_q;
    assign wb_rd         = wb_rd_q;
    assign wb_reg_write  = wb_regw_q;
    assign wb_misaligned = wb_mis_q;

    lsu_lane_align u_lane_align (
        .funct3_i     (funct3_q),
        .offset_i     (addr_q[1:0]),
        .store_data_i (sdata_q),
        .rdata_i      (mem_rdata),
        .be_o         (lane_be),
        .wdata_o      (lane_wdata),
        .load_data_o  (lane_load)
    );

    // Next-state and writeback decisions; a flushed access keeps the bus handshake but suppresses its beat.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        sdata_d    = sdata_q;
        funct3_d   = funct3_q;
        we_d       = we_q;
        rd_d       = rd_q;
        regw_d     = regw_q;
        kill_d     = kill_q;
        wb_valid_d = 1'b0;
        wb_data_d  = wb_data_q;
        wb_rd_d    = wb_rd_q;
        wb_regw_d  = wb_regw_q;
        wb_mis_d   = wb_mis_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!is_mem) begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = ex_alu_result;
                        wb_rd_d    = ex_rd;
                        wb_regw_d  = ex_reg_write;
                        wb_mis_d   = 1'b0;
                    end else if (misaligned) begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = ex_alu_result;
                        wb_rd_d    = ex_rd;
                        wb_regw_d  = 1'b0;
                        wb_mis_d   = 1'b1;
                    end else begin
                        addr_d   = ex_alu_result;
                        sdata_d  = ex_store_data;
                        funct3_d = ex_funct3;
                        we_d     = ex_mem_write;
                        rd_d     = ex_rd;
                        regw_d   = ex_reg_write && ex_mem_read;
                        kill_d   = 1'b0;
                        state_d  = REQ;
                    end
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    if (we_q) begin
                        state_d = IDLE;
                        if (!flush) begin
                            wb_valid_d = 1'b1;
                            wb_data_d  = addr_q;
                            wb_rd_d    = rd_q;
                            wb_regw_d  = 1'b0;
                            wb_mis_d   = 1'b0;
                        end
                    end else begin
                        state_d = WAIT;
                        kill_d  = flush;
                    end
                end else if (flush) begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (flush) begin
                    kill_d = 1'b1;
                end
                if (mem_rvalid) begin
                    state_d = IDLE;
                    if (!(kill_q || flush)) begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = lane_load;
                        wb_rd_d    = rd_q;
                        wb_regw_d  = regw_q;
                        wb_mis_d   = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and op registers; reset drops any in-flight access at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            sdata_q    <= '0;
            funct3_q   <= '0;
            we_q       <= 1'b0;
            rd_q       <= '0;
            regw_q     <= 1'b0;
            kill_q     <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
            wb_regw_q  <= 1'b0;
            wb_mis_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            sdata_q    <= sdata_d;
            funct3_q   <= funct3_d;
            we_q       <= we_d;
            rd_q       <= rd_d;
            regw_q     <= regw_d;
            kill_q     <= kill_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
            wb_regw_q  <= wb_regw_d;
            wb_mis_q   <= wb_mis_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for the load/store unit: directed vector table, randomized ops against
// an arithmetic reference model, and hand-built flush/reset sequences.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_store_data;
    logic [2:0]  ex_funct3;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic        wb_misaligned;

    int nChecks = 0;
    int nFails  = 0;

    typedef struct {
        logic        isLoad;
        logic        isStore;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        regw;
        logic [31:0] expData;
        logic [3:0]  expBe;
        logic [31:0] expWdata;
        logic        expMis;
    } vec_t;

    vec_t vecs[16];

    load_store_unit #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clk           (clk),
        .reset         (reset),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_alu_result (ex_alu_result),
        .ex_store_data (ex_store_data),
        .ex_funct3     (ex_funct3),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_reg_write),
        .flush         (flush),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_we        (mem_we),
        .mem_be        (mem_be),
        .mem_wdata     (mem_wdata),
        .mem_gnt       (mem_gnt),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .wb_valid      (wb_valid),
        .wb_data       (wb_data),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .wb_misaligned (wb_misaligned)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Reference model: access width in bytes from the funct3 rules.
    function automatic int accessBytes(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic logic modelMis(input logic [2:0] f3, input logic [31:0] addr);
        int off;
        off = int'(addr % 4);
        return (off % accessBytes(f3)) != 0;
    endfunction

    function automatic logic [3:0] modelBe(input logic [2:0] f3, input logic [31:0] addr);
        int n;
        int off;
        n   = accessBytes(f3);
        off = int'(addr % 4);
        if (n == 4) return 4'hF;
        return 4'(((1 << n) - 1) << off);
    endfunction

    function automatic logic [31:0] modelWdata(input logic [2:0] f3, input logic [31:0] sd);
        int n;
        n = accessBytes(f3);
        if (n == 1) return (sd & 32'hFF) * 32'h0101_0101;
        if (n == 2) return (sd & 32'hFFFF) * 32'h0001_0001;
        return sd;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] addr,
                                              input logic [31:0] rdata);
        int      n;
        int      off;
        longint  v;
        longint  range;
        logic    isSigned;
        n        = accessBytes(f3);
        off      = int'(addr % 4);
        range    = longint'(1) << (8 * n);
        v        = longint'(rdata >> (8 * off)) % range;
        isSigned = (f3 == 3'b000) || (f3 == 3'b001);
        if (isSigned && n < 4 && v >= range / 2) v = v - range;
        return 32'(v);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idleInputs();
        ex_valid      = 1'b0;
        ex_mem_read   = 1'b0;
        ex_mem_write  = 1'b0;
        flush         = 1'b0;
        mem_gnt       = 1'b0;
        mem_rvalid    = 1'b0;
        ex_alu_result = $urandom;
        ex_store_data = $urandom;
        ex_funct3     = 3'($urandom);
        ex_rd         = 5'($urandom);
        ex_reg_write  = 1'($urandom);
        mem_rdata     = $urandom;
    endtask

    task automatic driveOp(input logic isLoad, input logic isStore, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] sdata);
        ex_valid      = 1'b1;
        ex_mem_read   = isLoad;
        ex_mem_write  = isStore;
        ex_funct3     = f3;
        ex_alu_result = addr;
        ex_store_data = sdata;
        ex_rd         = 5'd3;
        ex_reg_write  = 1'b1;
    endtask

    // Runs one op end to end with the given bus delays and checks every cycle of it.
    task automatic applyStimulus(input logic isLoad, input logic isStore, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] sdata,
                                 input logic [31:0] rdata, input logic [4:0] rd, input logic regw,
                                 input int gntDly, input int rvDly,
                                 input logic [31:0] expData, input logic [3:0] expBe,
                                 input logic [31:0] expWdata, input logic expMis);
        logic [31:0] expAddr;
        expAddr = addr & 32'hFFFF_FFFC;
        checkOutput("ex_ready before accept", ex_ready, 1);
        ex_valid      = 1'b1;
        ex_mem_read   = isLoad;
        ex_mem_write  = isStore;
        ex_funct3     = f3;
        ex_alu_result = addr;
        ex_store_data = sdata;
        ex_rd         = rd;
        ex_reg_write  = regw;
        step();
        idleInputs();
        if (!(isLoad || isStore) || expMis) begin
            checkOutput("wb_valid latency1", wb_valid, 1);
            checkOutput("mem_req none", mem_req, 0);
            checkOutput("wb_misaligned", wb_misaligned, expMis);
            checkOutput("wb_rd", wb_rd, rd);
            if (expMis) begin
                checkOutput("wb_reg_write misaligned", wb_reg_write, 0);
            end else begin
                checkOutput("wb_reg_write passthru", wb_reg_write, regw);
                checkOutput("wb_data passthru", wb_data, expData);
            end
        end else begin
            for (int k = 0; k <= gntDly; k++) begin
                checkOutput("mem_req held", mem_req, 1);
                checkOutput("mem_addr", mem_addr, expAddr);
                checkOutput("mem_we", mem_we, isStore);
                checkOutput("mem_be", mem_be, expBe);
                if (isStore) checkOutput("mem_wdata", mem_wdata, expWdata);
                checkOutput("ex_ready busy", ex_ready, 0);
                checkOutput("wb_valid quiet REQ", wb_valid, 0);
                if (k == gntDly) mem_gnt = 1'b1;
                step();
                mem_gnt = 1'b0;
            end
            if (isStore) begin
                checkOutput("store wb_valid", wb_valid, 1);
                checkOutput("store wb_reg_write", wb_reg_write, 0);
                checkOutput("store wb_misaligned", wb_misaligned, 0);
                checkOutput("mem_req after store", mem_req, 0);
            end else begin
                for (int k = 0; k < rvDly; k++) begin
                    checkOutput("wb_valid quiet WAIT", wb_valid, 0);
                    checkOutput("ex_ready WAIT", ex_ready, 0);
                    step();
                end
                checkOutput("mem_req WAIT", mem_req, 0);
                mem_rvalid = 1'b1;
                mem_rdata  = rdata;
                step();
                mem_rvalid = 1'b0;
                mem_rdata  = $urandom;
                checkOutput("load wb_valid", wb_valid, 1);
                checkOutput("load wb_data", wb_data, expData);
                checkOutput("load wb_rd", wb_rd, rd);
                checkOutput("load wb_reg_write", wb_reg_write, regw);
                checkOutput("load wb_misaligned", wb_misaligned, 0);
            end
        end
        step();
        checkOutput("wb_valid single pulse", wb_valid, 0);
        checkOutput("ex_ready after op", ex_ready, 1);
    endtask

    initial begin
        logic [2:0]  f3Pool [8];
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] rdat;
        logic [4:0]  rd;
        logic        regw;
        int          kind;

        f3Pool = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};

        vecs[0]  = '{1'b0, 1'b0, 3'b010, 32'h0000_1234, 32'h0, 32'h0,         5'd5, 1'b1, 32'h0000_1234, 4'h0,    32'h0,         1'b0};
        vecs[1]  = '{1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0000_00AB, 32'h0, 5'd1, 1'b1, 32'h0,         4'b1000, 32'hABAB_ABAB, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0202, 32'h0, 32'h8001_7FFF, 5'd7, 1'b1, 32'hFFFF_8001, 4'b1100, 32'h0,         1'b0};
        vecs[3]  = '{1'b1, 1'b0, 3'b101, 32'h0000_0202, 32'h0, 32'h8001_7FFF, 5'd8, 1'b1, 32'h0000_8001, 4'b1100, 32'h0,         1'b0};
        vecs[4]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0201, 32'h0, 32'h8001_7FFF, 5'd2, 1'b1, 32'h0000_007F, 4'b0010, 32'h0,         1'b0};
        vecs[5]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0, 32'h0,         5'd9, 1'b1, 32'h0,         4'h0,    32'h0,         1'b1};
        vecs[6]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h1234_BEEF, 32'h0, 5'd4, 1'b0, 32'h0,         4'b1100, 32'hBEEF_BEEF, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 3'b010, 32'h0000_0200, 32'hDEAD_BEEF, 32'h0, 5'd6, 1'b1, 32'h0,         4'b1111, 32'hDEAD_BEEF, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 3'b100, 32'h0000_0303, 32'h0, 32'h8000_0000, 5'd10, 1'b1, 32'h0000_0080, 4'b1000, 32'h0,        1'b0};
        vecs[9]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0303, 32'h0, 32'h8000_0000, 5'd11, 1'b1, 32'hFFFF_FF80, 4'b1000, 32'h0,        1'b0};
        vecs[10] = '{1'b1, 1'b0, 3'b001, 32'h0000_0001, 32'h0, 32'h0,         5'd12, 1'b1, 32'h0,         4'h0,    32'h0,        1'b1};
        vecs[11] = '{1'b1, 1'b0, 3'b011, 32'h0000_0400, 32'h0, 32'h1234_5678, 5'd13, 1'b1, 32'h1234_5678, 4'b1111, 32'h0,        1'b0};
        vecs[12] = '{1'b1, 1'b0, 3'b110, 32'h0000_0402, 32'h0, 32'h0,         5'd14, 1'b1, 32'h0,         4'h0,    32'h0,        1'b1};
        vecs[13] = '{1'b0, 1'b1, 3'b000, 32'h0000_0100, 32'hFFFF_FF5A, 32'h0, 5'd15, 1'b1, 32'h0,         4'b0001, 32'h5A5A_5A5A, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 3'b101, 32'h0000_0000, 32'h0, 32'h1234_F00D, 5'd16, 1'b0, 32'h0000_F00D, 4'b0011, 32'h0,        1'b0};
        vecs[15] = '{1'b0, 1'b1, 3'b111, 32'h0000_0404, 32'hCAFE_F00D, 32'h0, 5'd17, 1'b1, 32'h0,         4'b1111, 32'hCAFE_F00D, 1'b0};

        idleInputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset ex_ready", ex_ready, 1);
        checkOutput("reset mem_req", mem_req, 0);
        checkOutput("reset mem_we", mem_we, 0);
        checkOutput("reset mem_be", mem_be, 0);
        checkOutput("reset mem_addr", mem_addr, 0);
        checkOutput("reset mem_wdata", mem_wdata, 0);
        checkOutput("reset wb_valid", wb_valid, 0);
        checkOutput("reset wb_data", wb_data, 0);
        checkOutput("reset wb_rd", wb_rd, 0);
        checkOutput("reset wb_reg_write", wb_reg_write, 0);
        checkOutput("reset wb_misaligned", wb_misaligned, 0);
        reset = 1'b0;
        step();

        $display("[TB] directed vector table");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].isLoad, vecs[i].isStore, vecs[i].f3, vecs[i].addr, vecs[i].sdata,
                          vecs[i].rdata, vecs[i].rd, vecs[i].regw, 0, 0, vecs[i].expData,
                          vecs[i].expBe, vecs[i].expWdata, vecs[i].expMis);
        end

        $display("[TB] LW with gnt delayed 3 cycles and rvalid 2 cycles after gnt");
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'h0, 32'h0BAD_CAFE, 5'd20, 1'b1, 3, 1,
                      32'h0BAD_CAFE, 4'b1111, 32'h0, 1'b0);

        $display("[TB] randomized ops against reference model");
        for (int i = 0; i < 60; i++) begin
            kind = int'($urandom_range(2, 0));
            f3   = f3Pool[$urandom_range(7, 0)];
            addr = $urandom;
            sd   = $urandom;
            rdat = $urandom;
            rd   = 5'($urandom);
            regw = 1'($urandom);
            if (kind == 0) begin
                applyStimulus(1'b0, 1'b0, f3, addr, sd, rdat, rd, regw, 0, 0, addr, 4'h0, 32'h0, 1'b0);
            end else begin
                applyStimulus(kind == 1, kind == 2, f3, addr, sd, rdat, rd, regw,
                              int'($urandom_range(3, 0)), int'($urandom_range(2, 0)),
                              modelLoad(f3, addr, rdat), modelBe(f3, addr), modelWdata(f3, sd),
                              modelMis(f3, addr));
            end
        end

        $display("[TB] flush in IDLE discards the incoming op");
        driveOp(1'b0, 1'b0, 3'b010, 32'h0000_7777, 32'h0);
        flush = 1'b1;
        step();
        idleInputs();
        checkOutput("flush idle wb_valid", wb_valid, 0);
        checkOutput("flush idle mem_req", mem_req, 0);

        $display("[TB] flush in WAIT then rvalid");
        driveOp(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0);
        step();
        idleInputs();
        checkOutput("flushWait mem_req", mem_req, 1);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        flush   = 1'b1;
        step();
        flush = 1'b0;
        checkOutput("flushWait still busy", ex_ready, 0);
        mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        checkOutput("flushWait wb suppressed", wb_valid, 0);
        checkOutput("flushWait ex_ready back", ex_ready, 1);
        step();
        checkOutput("flushWait no late wb", wb_valid, 0);

        $display("[TB] flush in REQ before gnt");
        driveOp(1'b0, 1'b1, 3'b010, 32'h0000_0020, 32'h1111_2222);
        step();
        idleInputs();
        checkOutput("flushReq mem_req", mem_req, 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        checkOutput("flushReq mem_req dropped", mem_req, 0);
        checkOutput("flushReq ex_ready", ex_ready, 1);
        checkOutput("flushReq wb_valid", wb_valid, 0);

        $display("[TB] flush together with gnt on a store");
        driveOp(1'b0, 1'b1, 3'b010, 32'h0000_0024, 32'h3333_4444);
        step();
        idleInputs();
        flush   = 1'b1;
        mem_gnt = 1'b1;
        step();
        flush   = 1'b0;
        mem_gnt = 1'b0;
        checkOutput("flushGntSt ex_ready", ex_ready, 1);
        checkOutput("flushGntSt wb_valid", wb_valid, 0);
        checkOutput("flushGntSt mem_req", mem_req, 0);

        $display("[TB] flush together with gnt on a load");
        driveOp(1'b1, 1'b0, 3'b010, 32'h0000_0028, 32'h0);
        step();
        idleInputs();
        flush   = 1'b1;
        mem_gnt = 1'b1;
        step();
        flush   = 1'b0;
        mem_gnt = 1'b0;
        checkOutput("flushGntLd waiting", ex_ready, 0);
        checkOutput("flushGntLd mem_req", mem_req, 0);
        mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        checkOutput("flushGntLd wb_valid", wb_valid, 0);
        checkOutput("flushGntLd ex_ready", ex_ready, 1);

        $display("[TB] reset asserted during REQ");
        driveOp(1'b1, 1'b0, 3'b001, 32'h0000_0046, 32'h0);
        step();
        idleInputs();
        checkOutput("rstReq mem_req before", mem_req, 1);
        #2 reset = 1'b1;
        #1;
        checkOutput("rstReq mem_req", mem_req, 0);
        checkOutput("rstReq mem_addr", mem_addr, 0);
        checkOutput("rstReq mem_be", mem_be, 0);
        checkOutput("rstReq mem_we", mem_we, 0);
        checkOutput("rstReq ex_ready", ex_ready, 1);
        checkOutput("rstReq wb_valid", wb_valid, 0);
        @(negedge clk);
        reset      = 1'b0;
        mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        checkOutput("rstReq stray rvalid", wb_valid, 0);
        checkOutput("rstReq idle after", ex_ready, 1);
        checkOutput("rstReq no req after", mem_req, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
